// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: buffers one symbol ahead and sends each symbol as a
// square-wave tone for SYM_CYCLES clocks, with the half-period chosen by the symbol value.
module mfsk_modulator #(
  parameter int unsigned SYM_BITS   = 1,
  parameter int unsigned SYM_CYCLES = 32,
  parameter int unsigned HP_BASE    = 2,
  parameter int unsigned HP_STEP    = 2,
  parameter int unsigned IDLE_TONE  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [SYM_BITS-1:0] sym_data_i,
  input  logic                sym_valid_i,
  output logic                sym_ready_o,
  output logic                fsk_out_o,
  output logic                busy_o,
  output logic                sym_strobe_o,
  output logic                underrun_o
);

  localparam int unsigned NUM_SYMS = 1 << SYM_BITS;
  localparam int unsigned HP_MAX   = HP_BASE + (NUM_SYMS - 1) * HP_STEP;
  localparam int unsigned CNT_W    = $clog2(SYM_CYCLES);
  localparam int unsigned HP_W     = $clog2(HP_MAX);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(SYM_CYCLES - 1);
  localparam logic [SYM_BITS-1:0] MARK_SYM = '1;

  typedef enum logic {IDLE, TX} state_e;

  state_e              state_q, state_d;
  logic [SYM_BITS-1:0] pend_data_q, pend_data_d;
  logic                pend_vld_q, pend_vld_d;
  logic [SYM_BITS-1:0] cur_sym_q, cur_sym_d;
  logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
  logic                fsk_q, fsk_d;
  logic                strobe_q, strobe_d;
  logic                underrun_q, underrun_d;
  logic                load_pend, load_mark;
  logic [HP_W-1:0]     hp_last;

  assign hp_last = HP_W'(32'(HP_BASE) - 32'd1 + 32'(cur_sym_q) * 32'(HP_STEP));

  always_comb begin
    state_d     = state_q;
    pend_data_d = pend_data_q;
    pend_vld_d  = pend_vld_q;
    cur_sym_d   = cur_sym_q;
    sym_cnt_d   = sym_cnt_q;
    hp_cnt_d    = hp_cnt_q;
    fsk_d       = fsk_q;
    strobe_d    = 1'b0;
    underrun_d  = 1'b0;
    load_pend   = 1'b0;
    load_mark   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_vld_q && en_i) load_pend = 1'b1;
      end
      TX: begin
        if (sym_cnt_q == LAST_CNT) begin
          if (!en_i) begin
            state_d   = IDLE;
            fsk_d     = 1'b0;
            sym_cnt_d = '0;
            hp_cnt_d  = '0;
          end else if (pend_vld_q) begin
            load_pend = 1'b1;
          end else begin
            underrun_d = 1'b1;
            if (IDLE_TONE != 0) begin
              load_mark = 1'b1;
            end else begin
              state_d   = IDLE;
              fsk_d     = 1'b0;
              sym_cnt_d = '0;
              hp_cnt_d  = '0;
            end
          end
        end else begin
          sym_cnt_d = sym_cnt_q + CNT_W'(1);
          if (hp_cnt_q == hp_last) begin
            hp_cnt_d = '0;
            fsk_d    = ~fsk_q;
          end else begin
            hp_cnt_d = hp_cnt_q + HP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load from TX keeps the current level so the tone is continuous across the boundary.
    if (load_pend || load_mark) begin
      cur_sym_d = load_pend ? pend_data_q : MARK_SYM;
      if (load_pend) pend_vld_d = 1'b0;
      sym_cnt_d = '0;
      hp_cnt_d  = '0;
      state_d   = TX;
      strobe_d  = 1'b1;
      if (state_q == IDLE) fsk_d = 1'b0;
    end

    if (sym_valid_i && !pend_vld_q) begin
      pend_vld_d  = 1'b1;
      pend_data_d = sym_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pend_data_q <= '0;
      pend_vld_q  <= 1'b0;
      cur_sym_q   <= '0;
      sym_cnt_q   <= '0;
      hp_cnt_q    <= '0;
      fsk_q       <= 1'b0;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_data_q <= pend_data_d;
      pend_vld_q  <= pend_vld_d;
      cur_sym_q   <= cur_sym_d;
      sym_cnt_q   <= sym_cnt_d;
      hp_cnt_q    <= hp_cnt_d;
      fsk_q       <= fsk_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sym_ready_o  = !pend_vld_q;
  assign fsk_out_o    = fsk_q;
  assign busy_o       = (state_q == TX);
  assign sym_strobe_o = strobe_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_mfsk_modulator.sv
// Bench for mfsk_modulator: three instances (binary, 4-ary, mark-filler) checked
// every cycle against a symbol-level model, plus hand-computed tone and timing figures.
module tb_mfsk_modulator;

  localparam int N = 3;

  int SB [N] = '{1, 2, 1};
  int SC [N] = '{32, 24, 32};
  int HB [N] = '{2, 1, 2};
  int HS [N] = '{2, 1, 2};
  int IT [N] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] en = '1;
  logic [N-1:0] valid = '0;
  logic [1:0] data [N] = '{default: 2'd0};
  wire [N-1:0] rdy, fsk, busy, strb, ur;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mfsk_modulator #(.SYM_BITS(1), .SYM_CYCLES(32), .HP_BASE(2), .HP_STEP(2), .IDLE_TONE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en[0]), .sym_data_i(data[0][0:0]), .sym_valid_i(valid[0]),
    .sym_ready_o(rdy[0]), .fsk_out_o(fsk[0]), .busy_o(busy[0]), .sym_strobe_o(strb[0]), .underrun_o(ur[0]));
  mfsk_modulator #(.SYM_BITS(2), .SYM_CYCLES(24), .HP_BASE(1), .HP_STEP(1), .IDLE_TONE(0)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en[1]), .sym_data_i(data[1]), .sym_valid_i(valid[1]),
    .sym_ready_o(rdy[1]), .fsk_out_o(fsk[1]), .busy_o(busy[1]), .sym_strobe_o(strb[1]), .underrun_o(ur[1]));
  mfsk_modulator #(.SYM_BITS(1), .SYM_CYCLES(32), .HP_BASE(2), .HP_STEP(2), .IDLE_TONE(1)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en[2]), .sym_data_i(data[2][0:0]), .sym_valid_i(valid[2]),
    .sym_ready_o(rdy[2]), .fsk_out_o(fsk[2]), .busy_o(busy[2]), .sym_strobe_o(strb[2]), .underrun_o(ur[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: a symbol is (value, start level, cycle index k); the level is start ^ parity of k/HP.
  bit   mAct [N];
  int   mK   [N];
  int   mCur [N];
  logic mBase[N];
  bit   mPv  [N];
  int   mPd  [N];
  bit   mStrb[N];
  bit   mUr  [N];

  function automatic int hpOf(int i);
    return HB[i] + mCur[i] * HS[i];
  endfunction

  function automatic logic modelFsk(int i);
    if (!mAct[i]) return 1'b0;
    return mBase[i] ^ 1'((mK[i] / hpOf(i)) % 2);
  endfunction

  task automatic startSym(int i, int s, logic lvl, bit fromPend);
    mCur[i] = s; mK[i] = 0; mBase[i] = lvl; mAct[i] = 1; mStrb[i] = 1;
    if (fromPend) mPv[i] = 0;
  endtask

  always @(posedge clk or posedge rst) begin : modelProc
    bit acc;
    logic lvl;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mAct[i] = 0; mK[i] = 0; mCur[i] = 0; mBase[i] = 0;
        mPv[i] = 0; mPd[i] = 0; mStrb[i] = 0; mUr[i] = 0;
      end else begin
        acc = valid[i] && !mPv[i];
        mStrb[i] = 0; mUr[i] = 0;
        if (!mAct[i]) begin
          if (mPv[i] && en[i]) startSym(i, mPd[i], 1'b0, 1);
        end else if (mK[i] < SC[i] - 1) begin
          mK[i]++;
        end else begin
          lvl = modelFsk(i);
          if (!en[i]) mAct[i] = 0;
          else if (mPv[i]) startSym(i, mPd[i], lvl, 1);
          else begin
            mUr[i] = 1;
            if (IT[i] != 0) startSym(i, (1 << SB[i]) - 1, lvl, 0);
            else mAct[i] = 0;
          end
        end
        if (acc) begin mPv[i] = 1; mPd[i] = int'(data[i]); end
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-symbol toggle counts, strobe times, underrun pulses and busy drops seen on each DUT.
  int   tog  [N][8];
  int   ntog [N];
  int   curTog[N];
  int   strbT[N][8];
  int   nstrb[N];
  int   urCnt[N];
  int   busyDrops[N];
  logic prevF[N];
  logic prevB[N];

  task automatic clearMon(int i);
    ntog[i] = 0; curTog[i] = 0; nstrb[i] = 0; urCnt[i] = 0; busyDrops[i] = 0;
  endtask

  task automatic pushTog(int i);
    if (ntog[i] < 8) tog[i][ntog[i]] = curTog[i];
    ntog[i]++;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("dut%0d fsk_out", i), 32'(fsk[i]), 32'(modelFsk(i)));
      checkOutput($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(mAct[i]));
      checkOutput($sformatf("dut%0d sym_strobe", i), 32'(strb[i]), 32'(mStrb[i]));
      checkOutput($sformatf("dut%0d underrun", i), 32'(ur[i]), 32'(mUr[i]));
      checkOutput($sformatf("dut%0d sym_ready", i), 32'(rdy[i]), 32'(!mPv[i]));

      if (ur[i] === 1'b1) urCnt[i]++;
      if (busy[i] === 1'b1 && strb[i] === 1'b1) begin
        if (prevB[i] === 1'b1) begin
          if (fsk[i] !== prevF[i]) curTog[i]++;
          pushTog(i);
        end
        curTog[i] = 0;
        if (nstrb[i] < 8) strbT[i][nstrb[i]] = cyc;
        nstrb[i]++;
      end else if (busy[i] === 1'b1) begin
        if (fsk[i] !== prevF[i]) curTog[i]++;
      end else if (prevB[i] === 1'b1) begin
        pushTog(i);
        busyDrops[i]++;
      end
      prevF[i] = fsk[i];
      prevB[i] = busy[i];
    end
  end

  // Offer one symbol from a falling edge and hold it until the DUT takes it.
  task automatic applyStimulus(int i, int val);
    bit took;
    took = 0;
    valid[i] = 1'b1;
    data[i] = 2'(val);
    for (int c = 0; c < 200 && !took; c++) begin
      took = rdy[i];
      @(negedge clk);
    end
    valid[i] = 1'b0;
    if (!took) checkOutput($sformatf("dut%0d accept timeout", i), 0, 1);
  endtask

  task automatic waitIdle(int i, int budget);
    for (int c = 0; c < budget && busy[i] === 1'b1; c++) @(negedge clk);
    checkOutput($sformatf("dut%0d returns idle", i), 32'(busy[i]), 0);
    checkOutput($sformatf("dut%0d fsk low when idle", i), 32'(fsk[i]), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      clearMon(i);
      prevF[i] = 1'b0;
      prevB[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("dut%0d reset fsk", i), 32'(fsk[i]), 0);
      checkOutput($sformatf("dut%0d reset busy", i), 32'(busy[i]), 0);
      checkOutput($sformatf("dut%0d reset ready", i), 32'(rdy[i]), 1);
      checkOutput($sformatf("dut%0d reset strobe", i), 32'(strb[i]), 0);
      checkOutput($sformatf("dut%0d reset underrun", i), 32'(ur[i]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("dut0 ready after reset", 32'(rdy[0]), 1);

    $display("[TB] binary tones 0,1 then underrun to idle");
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    waitIdle(0, 200);
    checkOutput("dut0 symbols seen", ntog[0], 2);
    checkOutput("dut0 sym0 toggles", tog[0][0], 15);
    checkOutput("dut0 sym1 toggles", tog[0][1], 7);
    checkOutput("dut0 strobe spacing", strbT[0][1] - strbT[0][0], 32);
    checkOutput("dut0 underrun pulses", urCnt[0], 1);

    $display("[TB] 4-ary tones 0,1,2,3");
    for (int s = 0; s < 4; s++) applyStimulus(1, s);
    waitIdle(1, 200);
    checkOutput("dut1 symbols seen", ntog[1], 4);
    checkOutput("dut1 sym0 toggles", tog[1][0], 23);
    checkOutput("dut1 sym1 toggles", tog[1][1], 11);
    checkOutput("dut1 sym2 toggles", tog[1][2], 7);
    checkOutput("dut1 sym3 toggles", tog[1][3], 5);
    for (int s = 1; s < 4; s++)
      checkOutput($sformatf("dut1 strobe spacing %0d", s), strbT[1][s] - strbT[1][s-1], 24);
    checkOutput("dut1 underrun pulses", urCnt[1], 1);

    $display("[TB] mark filler on underrun");
    applyStimulus(2, 1);
    for (int c = 0; c < 400 && urCnt[2] < 3; c++) @(negedge clk);
    checkOutput("dut2 three underruns", urCnt[2], 3);
    checkOutput("dut2 busy held through marks", busyDrops[2], 0);
    applyStimulus(2, 0);
    for (int c = 0; c < 200 && nstrb[2] < 5; c++) @(negedge clk);
    @(negedge clk);
    en[2] = 1'b0;
    waitIdle(2, 100);
    en[2] = 1'b1;
    checkOutput("dut2 underruns total", urCnt[2], 3);
    checkOutput("dut2 symbols seen", ntog[2], 5);
    checkOutput("dut2 sym1 toggles", tog[2][0], 7);
    for (int s = 1; s < 4; s++)
      checkOutput($sformatf("dut2 mark%0d toggles", s), tog[2][s], 7);
    checkOutput("dut2 late symbol toggles", tog[2][4], 15);
    checkOutput("dut2 late symbol on boundary", strbT[2][4] - strbT[2][3], 32);
    checkOutput("dut2 single busy drop", busyDrops[2], 1);

    $display("[TB] backpressure with enable drop");
    clearMon(1);
    fork
      begin
        for (int s = 0; s < 6; s++) applyStimulus(1, s % 4);
      end
      begin
        repeat (34) @(negedge clk);
        en[1] = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("dut1 no underrun on disable", urCnt[1], 0);
        checkOutput("dut1 idle while disabled", 32'(busy[1]), 0);
        checkOutput("dut1 symbol held while disabled", 32'(rdy[1]), 0);
        en[1] = 1'b1;
        @(negedge clk);
        checkOutput("dut1 held symbol loads on enable", 32'(strb[1]), 1);
      end
    join
    for (int c = 0; c < 400 && ntog[1] < 6; c++) @(negedge clk);
    checkOutput("dut1 symbols after backpressure", ntog[1], 6);
    checkOutput("dut1 bp sym0", tog[1][0], 23);
    checkOutput("dut1 bp sym1", tog[1][1], 11);
    checkOutput("dut1 bp sym2", tog[1][2], 7);
    checkOutput("dut1 bp sym3", tog[1][3], 5);
    checkOutput("dut1 bp sym4", tog[1][4], 23);
    checkOutput("dut1 bp sym5", tog[1][5], 11);
    checkOutput("dut1 bp underruns", urCnt[1], 1);

    $display("[TB] asynchronous reset mid-symbol");
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    repeat (5) @(negedge clk);
    checkOutput("dut0 busy before reset", 32'(busy[0]), 1);
    checkOutput("dut0 pending before reset", 32'(rdy[0]), 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("dut0 async reset fsk", 32'(fsk[0]), 0);
    checkOutput("dut0 async reset busy", 32'(busy[0]), 0);
    checkOutput("dut0 async reset ready", 32'(rdy[0]), 1);
    checkOutput("dut0 async reset strobe", 32'(strb[0]), 0);
    checkOutput("dut0 async reset underrun", 32'(ur[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("dut0 pending discarded", 32'(busy[0]), 0);
    checkOutput("dut0 ready after release", 32'(rdy[0]), 1);
    checkOutput("dut0 fsk after release", 32'(fsk[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
